// File: rtl/key_ctrl_pkg.sv
// Shared types and default timing constants for the push-button front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_ctrl_pkg;

  // Press-classification FSM states
  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    LONG_HELD,
    DB_RELEASE
  } state_e;

  // What a completed press is classified as when the release is accepted
  typedef enum logic {
    SHORT,
    LONG
  } kind_e;

  // Defaults for a 12 MHz clock: 20 ms debounce, 1 s long-press threshold
  localparam int unsigned DEBOUNCE_CYC_DEF = 240_000;
  localparam int unsigned LONG_CYC_DEF     = 12_000_000;
  localparam int unsigned CNT_W_DEF        = 24;

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchronizer for an asynchronous level, idles high after reset.
// Latency: 2 cycles from d_i to q_o.
// Backpressure: none, free-running.
module key_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Resolve metastability on the raw key level; reset to the released level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/key_press_ctrl.sv
// Debounces an active-low key and classifies presses: short toggles run, long clears.
// Latency: key edge to pressed/short_pulse is 2 + DEBOUNCE_CYC + 1 cycles.
// Backpressure: none; pulses are fire-and-forget, one cycle wide.
module key_press_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned LONG_CYC     = LONG_CYC_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic run,
  output logic clr_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic pressed
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);

  logic             key_s;
  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             pressed_q, pressed_d;
  logic             run_q, run_d;
  logic             short_q, short_d;
  // Long threshold is flagged at the state change and the pulse lands one cycle later
  logic             long_arm_q, long_arm_d;
  logic             long_q, long_d;

  key_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (key_n),
    .q_o (key_s)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      kind_q     <= SHORT;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      pressed_q  <= 1'b0;
      run_q      <= 1'b0;
      short_q    <= 1'b0;
      long_arm_q <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      pressed_q  <= pressed_d;
      run_q      <= run_d;
      short_q    <= short_d;
      long_arm_q <= long_arm_d;
      long_q     <= long_d;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    pressed_d  = pressed_q;
    run_d      = run_q;
    short_d    = 1'b0;
    long_arm_d = 1'b0;
    long_d     = long_arm_q;
    // A long press only ever forces run low, together with the clear pulse
    if (long_arm_q) run_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
          pressed_d  = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
        // Reaching the threshold beats a simultaneous release
        if (hold_cnt_q == LONG_LAST) begin
          state_d    = LONG_HELD;
          long_arm_d = 1'b1;
        end else if (key_s) begin
          state_d  = DB_RELEASE;
          db_cnt_d = '0;
          kind_d   = SHORT;
        end
      end
      LONG_HELD: begin
        if (key_s) begin
          state_d  = DB_RELEASE;
          db_cnt_d = '0;
          kind_d   = LONG;
        end
      end
      DB_RELEASE: begin
        // hold_cnt is left untouched so a bounce resumes the hold where it was
        if (!key_s) begin
          state_d = (kind_q == LONG) ? LONG_HELD : PRESSED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
          if (kind_q == SHORT) begin
            short_d = 1'b1;
            run_d   = ~run_q;
          end
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign run         = run_q;
  assign pressed     = pressed_q;
  assign short_pulse = short_q;
  assign long_pulse  = long_q;
  assign clr_pulse   = long_q;

endmodule

// File: tb/tb_key_press_ctrl.sv
// Randomized and directed bench for key_press_ctrl with a streak-based reference model.
// Latency: model predicts every output on every clock.
// Backpressure: n/a.
module tb_key_press_ctrl;

  localparam int DB = 4;
  localparam int LG = 20;

  logic clk = 1'b0;
  logic rst;
  logic key_n;
  logic run, clr_pulse, short_pulse, long_pulse, pressed;

  always #5 clk = ~clk;

  key_press_ctrl #(
    .DEBOUNCE_CYC (DB),
    .LONG_CYC     (LG),
    .CNT_W        (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .run         (run),
    .clr_pulse   (clr_pulse),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .pressed     (pressed)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference model: key history as consecutive-sample streaks rather than FSM states
  bit m_s1, m_s2;
  int m_hi, m_lo, m_held;
  bit m_pressed, m_long, m_run, m_short, m_lp, m_arm;

  int cyc = 0;
  int n_short = 0;
  int n_clr = 0;

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1;
    m_hi = 0; m_lo = 0; m_held = 0;
    m_pressed = 0; m_long = 0; m_run = 0;
    m_short = 0; m_lp = 0; m_arm = 0;
  endtask

  task automatic model_edge();
    bit s;
    int hprev;
    s = m_s2;
    m_s2 = m_s1;
    m_s1 = key_n;
    hprev = m_hi;
    if (s) begin m_hi++; m_lo = 0; end
    else   begin m_lo++; m_hi = 0; end
    m_short = 0;
    m_lp = m_arm;
    if (m_arm) m_run = 0;
    m_arm = 0;
    if (!m_pressed) begin
      // accepted after DB+1 consecutive low samples
      if (m_lo == DB + 1) begin
        m_pressed = 1; m_long = 0; m_held = 0;
      end
    end else if (!m_long && hprev == 0) begin
      // steadily held (no pending release): count hold time
      if (m_held == LG - 1) begin
        m_long = 1; m_arm = 1;
        m_hi = 0;  // the sample that decided "long" does not start the release
      end else begin
        m_held++;
      end
    end else if (m_hi == DB + 1) begin
      m_pressed = 0;
      if (!m_long) begin m_short = 1; m_run = !m_run; end
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({run, clr_pulse, short_pulse, long_pulse, pressed});
  endfunction

  function automatic logic [31:0] mdl_vec();
    return 32'({m_run, m_lp, m_short, m_lp, m_pressed});
  endfunction

  task automatic step(input logic k);
    key_n = k;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_eq("cycle_outs", dut_vec(), mdl_vec());
    if (short_pulse) n_short++;
    if (clr_pulse)   n_clr++;
    cyc++;
  endtask

  task automatic hold(input logic k, input int n);
    repeat (n) step(k);
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must clear before any edge
  task automatic mid_reset(input logic k);
    #2 rst = 1'b1;
    #1 model_reset();
    check_eq("async_rst", dut_vec(), 32'd0);
    hold(k, 2);
    #2 rst = 1'b0;
  endtask

  initial begin
    int n, s0, c0, t_press, t_long, nl;
    logic lvl;
    rst = 1'b1;
    key_n = 1'b0;
    model_reset();
    #3;
    check_eq("reset_outs", dut_vec(), 32'd0);
    hold(1'b0, 2);
    #2 rst = 1'b0;

    // 1: key held through reset release -> fresh debounce, pressed on 7th edge
    n = 0;
    while (!pressed && n < 50) begin step(1'b0); n++; end
    check_eq("t1_press_latency", 32'(n), 32'd7);
    hold(1'b1, 12);
    check_eq("t1_run", 32'(run), 32'd1);

    // 2: two short presses toggle run back and forth
    s0 = n_short;
    hold(1'b0, 10); hold(1'b1, 12);
    check_eq("t2_run_a", 32'(run), 32'd0);
    hold(1'b0, 10); hold(1'b1, 12);
    check_eq("t2_run_b", 32'(run), 32'd1);
    check_eq("t2_shorts", 32'(n_short - s0), 32'd2);

    // 3: a 2-cycle glitch changes nothing
    s0 = n_short;
    hold(1'b0, 2); hold(1'b1, 10);
    check_eq("t3_run", 32'(run), 32'd1);
    check_eq("t3_pressed", 32'(pressed), 32'd0);
    check_eq("t3_shorts", 32'(n_short - s0), 32'd0);

    // 4: long hold -> single long/clear pulse 21 cycles after pressed, run forced low
    s0 = n_short; t_press = -1; t_long = -1; nl = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0);
      if (pressed && t_press < 0) t_press = cyc;
      if (long_pulse) begin t_long = cyc; nl++; end
    end
    check_eq("t4_long_delay", 32'(t_long - t_press), 32'd21);
    check_eq("t4_long_count", 32'(nl), 32'd1);
    check_eq("t4_run", 32'(run), 32'd0);
    hold(1'b1, 12);
    check_eq("t4_no_short", 32'(n_short - s0), 32'd0);

    // 5: bounce mid-hold is absorbed, hold continues to a long press
    hold(1'b0, 10); hold(1'b1, 12);
    check_eq("t5_run_pre", 32'(run), 32'd1);
    s0 = n_short; c0 = n_clr;
    hold(1'b0, 10); hold(1'b1, 2); hold(1'b0, 30); hold(1'b1, 12);
    check_eq("t5_clr_count", 32'(n_clr - c0), 32'd1);
    check_eq("t5_no_short", 32'(n_short - s0), 32'd0);
    check_eq("t5_run", 32'(run), 32'd0);

    // 6: reset while pressed with run high; later release gives no short pulse
    hold(1'b0, 10); hold(1'b1, 12);
    check_eq("t6_run_pre", 32'(run), 32'd1);
    hold(1'b0, 12);
    check_eq("t6_pressed_pre", 32'(pressed), 32'd1);
    s0 = n_short;
    mid_reset(1'b0);
    hold(1'b0, 3); hold(1'b1, 12);
    check_eq("t6_no_short", 32'(n_short - s0), 32'd0);
    check_eq("t6_run", 32'(run), 32'd0);

    // Random key traffic: bounces, short and long holds, occasional reset
    lvl = 1'b1;
    for (int seg = 0; seg < 300; seg++) begin
      int cat, len;
      lvl = ~lvl;
      cat = $urandom_range(0, 9);
      if (cat < 4)      len = $urandom_range(1, 4);
      else if (cat < 8) len = $urandom_range(5, 16);
      else              len = $urandom_range(22, 45);
      hold(lvl, len);
      if ($urandom_range(0, 39) == 0) mid_reset(lvl);
    end
    hold(1'b1, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
